// File: rtl/dvid2vga_if.sv
// Lane words into the TMDS receiver and decoded VGA-domain signals out of it.
interface dvid2vga_if;
    logic [9:0] in_red, in_green, in_blue;
    logic [7:0] out_red, out_green, out_blue;
    logic       out_hsync, out_vsync, out_blank, out_locked;
    logic [3:0] out_offset;

    modport master (
        output in_red, in_green, in_blue,
        input  out_red, out_green, out_blue, out_hsync, out_vsync,
        input  out_blank, out_locked, out_offset
    );

    modport slave (
        input  in_red, in_green, in_blue,
        output out_red, out_green, out_blue, out_hsync, out_vsync,
        output out_blank, out_locked, out_offset
    );
endinterface

// File: rtl/dvid2vga.sv
// TMDS receiver: hunts symbol alignment on control-token runs, then decodes
// the three lanes back to 8-bit RGB plus hsync/vsync/blank.
module dvid2vga_lane (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] din,
    input  logic [3:0] offset,
    output logic       is_tok,
    output logic [1:0] ctl,
    output logic [7:0] data
);
    logic [9:0] r0, r1, sym;
    logic [9:0] aligned;
    logic [7:0] t;

    // r1 is the older word, so it forms the low half of the window
    assign aligned = 10'({r0, r1} >> offset);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r0  <= '0;
            r1  <= '0;
            sym <= '0;
        end else begin
            r0  <= din;
            r1  <= r0;
            sym <= aligned;
        end
    end

    always_comb begin
        is_tok = 1'b1;
        ctl    = 2'b00;
        case (sym)
            10'h354: ctl = 2'b00;
            10'h0AB: ctl = 2'b01;
            10'h154: ctl = 2'b10;
            10'h2AB: ctl = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    always_comb begin
        t       = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = '0;
        data[0] = t[0];
        for (int i = 1; i < 8; i++)
            data[i] = sym[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
endmodule

module dvid2vga #(
    parameter int C_lock_tokens = 8,
    parameter int C_timeout     = 4096
) (
    input  logic      clk_pixel,
    input  logic      reset_n,
    dvid2vga_if.slave bus
);
    localparam int NUM_LANES = 3;
    localparam int RUN_W     = $clog2(C_lock_tokens + 1);
    localparam int WD_W      = $clog2(C_timeout + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(C_lock_tokens);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(C_timeout);
    localparam logic [WD_W-1:0]  WD_SLIP = WD_W'(C_timeout - 1);
    localparam logic [0:0] S_SEARCH = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    // lane 0 = blue (carries the syncs), 1 = green, 2 = red
    logic [NUM_LANES-1:0][9:0] lane_in;
    logic [NUM_LANES-1:0]      lane_tok;
    logic [NUM_LANES-1:0][1:0] lane_ctl;
    logic [NUM_LANES-1:0][7:0] lane_data;

    logic [0:0]                state, state_nxt;
    logic [3:0]                offset;
    logic [RUN_W-1:0]          run, run_inc;
    logic [WD_W-1:0]           wd;
    logic                      all_tok, hit, slip;
    logic [1:0]                held;
    logic [NUM_LANES-1:0][7:0] rgb;
    logic                      hsync, vsync, blank;
    logic                      unused_ctl;

    assign lane_in = {bus.in_red, bus.in_green, bus.in_blue};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            dvid2vga_lane u_lane (
                .clk_pixel (clk_pixel),
                .reset_n   (reset_n),
                .din       (lane_in[g]),
                .offset    (offset),
                .is_tok    (lane_tok[g]),
                .ctl       (lane_ctl[g]),
                .data      (lane_data[g])
            );
        end
    endgenerate

    assign unused_ctl = ^lane_ctl[NUM_LANES-1:1];

    always_comb begin
        all_tok   = &lane_tok;
        run_inc   = all_tok ? ((run == RUN_MAX) ? run : run + 1'b1) : '0;
        hit       = all_tok && (run_inc == RUN_MAX);
        // a lock on the same edge as a watchdog expiry suppresses the slip
        slip      = !hit && (wd == WD_SLIP);
        state_nxt = hit ? S_LOCKED : (slip ? S_SEARCH : state);
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_SEARCH;
            offset <= '0;
            run    <= '0;
            wd     <= '0;
            held   <= '0;
            rgb    <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            blank  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (hit) begin
                run <= run_inc;
                wd  <= '0;
            end else if (slip) begin
                run    <= '0;
                wd     <= '0;
                offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            end else begin
                run <= run_inc;
                if (wd != WD_MAX)
                    wd <= wd + 1'b1;
            end

            if (all_tok)
                held <= lane_ctl[0];

            // gate on the next state so the lock edge already shows token syncs
            if (state_nxt == S_LOCKED && all_tok) begin
                blank          <= 1'b1;
                rgb            <= '0;
                {vsync, hsync} <= lane_ctl[0];
            end else if (state_nxt == S_LOCKED) begin
                blank          <= 1'b0;
                rgb            <= lane_data;
                {vsync, hsync} <= held;
            end else begin
                blank          <= 1'b1;
                rgb            <= '0;
                {vsync, hsync} <= 2'b00;
            end
        end
    end

    assign bus.out_blue   = rgb[0];
    assign bus.out_green  = rgb[1];
    assign bus.out_red    = rgb[2];
    assign bus.out_hsync  = hsync;
    assign bus.out_vsync  = vsync;
    assign bus.out_blank  = blank;
    assign bus.out_locked = (state == S_LOCKED);
    assign bus.out_offset = offset;
endmodule

// File: tb/tb_dvid2vga.sv
// Directed bench for dvid2vga: lock, loopback, token/data decode, timeout,
// async reset and rotated-stream acquisition.
module tb_dvid2vga;
    typedef struct packed {
        logic       blank;
        logic       vs;
        logic       hs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dvid2vga_if ifc ();

    dvid2vga dut (
        .clk_pixel (clk),
        .reset_n   (rst_n),
        .bus       (ifc)
    );

    // hand-decoded data symbols and their 8-bit values
    logic [9:0] DSYM [6] = '{10'h100, 10'h2FF, 10'h1FF, 10'h155, 10'h200, 10'h3F0};
    logic [7:0] DVAL [6] = '{8'h00,   8'hFE,   8'h01,   8'hFF,   8'hFF,   8'h11};

    int         n_vec = 0, n_err = 0;
    int         cyc = 0, lp = 0, rot = 0, nslip = 0;
    int         took, d0, k;
    logic [3:0] last_off = 4'd0;
    logic [9:0] prev_r = '0, prev_g = '0, prev_b = '0;
    logic       held_hs = 1'b0, held_vs = 1'b0;
    bit         chk_en = 1'b0;
    exp_t       hist [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] rotw(input logic [9:0] cur, input logic [9:0] prev, input int r);
        logic [19:0] w;
        w = {cur, prev};
        return 10'(w >> (10 - r));
    endfunction

    function automatic logic [7:0] dval(input logic [9:0] s);
        for (int i = 0; i < 6; i++)
            if (DSYM[i] == s) return DVAL[i];
        return 8'h00;
    endfunction

    // {is_token, vsync, hsync}
    function automatic logic [2:0] tokc(input logic [9:0] s);
        case (s)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t got_now();
        return {ifc.out_blank, ifc.out_vsync, ifc.out_hsync, ifc.out_red, ifc.out_green, ifc.out_blue};
    endfunction

    // one pixel: observe after the edge, then drive the next symbol set
    task automatic step(input logic [9:0] sr, input logic [9:0] sg, input logic [9:0] sb);
        exp_t       e;
        logic [2:0] tr, tg, tkb;
        @(posedge clk);
        cyc++;
        #1;
        if (ifc.out_offset != last_off) begin
            nslip++;
            last_off = ifc.out_offset;
        end
        if (chk_en) chk("loop", got_now(), hist[(cyc - 4) & 7]);
        ifc.in_red   = rotw(sr, prev_r, rot);
        ifc.in_green = rotw(sg, prev_g, rot);
        ifc.in_blue  = rotw(sb, prev_b, rot);
        prev_r = sr;
        prev_g = sg;
        prev_b = sb;
        tr = tokc(sr);
        tg = tokc(sg);
        tkb = tokc(sb);
        if (tr[2] && tg[2] && tkb[2]) begin
            held_vs = tkb[1];
            held_hs = tkb[0];
            e = {1'b1, tkb[1], tkb[0], 24'h0};
        end else begin
            e = {1'b0, held_vs, held_hs, dval(sr), dval(sg), dval(sb)};
        end
        hist[cyc & 7] = e;
    endtask

    task automatic data_step(input int i);
        step(DSYM[i % 6], DSYM[(i + 2) % 6], DSYM[(i + 4) % 6]);
    endtask

    // 64-pixel lines: 8 tokens with syncs 00, 8 with hsync=1, 48 data
    task automatic stream_step();
        if (lp < 8)       step(10'h354, 10'h354, 10'h354);
        else if (lp < 16) step(10'h354, 10'h354, 10'h0AB);
        else              data_step(lp - 16);
        lp = (lp + 1) % 64;
    endtask

    task automatic wait_lock(input int max, output int n);
        n = 0;
        while (!ifc.out_locked && n < max) begin
            stream_step();
            n++;
        end
    endtask

    task automatic mid_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ifc.in_red = '0;
        ifc.in_green = '0;
        ifc.in_blue = '0;
        #1;
        chk({tag, "_locked"}, ifc.out_locked, 1'b0);
        chk({tag, "_blank"},  ifc.out_blank, 1'b1);
        chk({tag, "_offset"}, ifc.out_offset, 4'd0);
        chk({tag, "_rgb"},    {ifc.out_red, ifc.out_green, ifc.out_blue}, 24'h0);
        chk({tag, "_syncs"},  {ifc.out_vsync, ifc.out_hsync}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_r = '0; prev_g = '0; prev_b = '0;
        held_hs = 1'b0; held_vs = 1'b0;
        lp = 0; nslip = 0; last_off = 4'd0;
    endtask

    initial begin
        ifc.in_red = '0;
        ifc.in_green = '0;
        ifc.in_blue = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", ifc.out_locked, 1'b0);
        chk("rst_blank",  ifc.out_blank, 1'b1);
        chk("rst_offset", ifc.out_offset, 4'd0);
        chk("rst_rgb",    {ifc.out_red, ifc.out_green, ifc.out_blue}, 24'h0);
        chk("rst_syncs",  {ifc.out_vsync, ifc.out_hsync}, 2'b00);
        rst_n = 1'b1;

        // aligned stream: 8th token leaves the pipeline on step 12
        wait_lock(64, took);
        chk("lock0", ifc.out_locked, 1'b1);
        chk("lock0_in_hblank", took <= 16, 1'b1);
        chk("lock0_offset", ifc.out_offset, 4'd0);
        chk_en = 1'b1;
        repeat (128) stream_step();
        chk_en = 1'b0;

        repeat (6) step(10'h354, 10'h354, 10'h2AB);
        chk("tok_hsync", ifc.out_hsync, 1'b1);
        chk("tok_vsync", ifc.out_vsync, 1'b1);
        chk("tok_blank", ifc.out_blank, 1'b1);
        chk("tok_rgb",   {ifc.out_red, ifc.out_green, ifc.out_blue}, 24'h0);

        repeat (6) step(10'h100, 10'h2FF, 10'h100);
        chk("dat_red",   ifc.out_red, 8'h00);
        chk("dat_green", ifc.out_green, 8'hFE);
        chk("dat_blue",  ifc.out_blue, 8'h00);
        chk("dat_blank", ifc.out_blank, 1'b0);
        chk("dat_syncs_held", {ifc.out_vsync, ifc.out_hsync}, 2'b11);

        repeat (6) step(10'h1FF, 10'h155, 10'h3F0);
        chk("dat2_rgb", {ifc.out_red, ifc.out_green, ifc.out_blue}, 24'h01FF11);
        chk("dat2_locked", ifc.out_locked, 1'b1);

        // watchdog: last qualifying run leaves s 3 edges after the first data
        // word is driven, then 4096 more edges to expiry
        repeat (16) step(10'h354, 10'h354, 10'h354);
        d0 = cyc + 1;
        k = 0;
        while (ifc.out_locked && k < 5000) begin
            data_step(k);
            k++;
        end
        chk("to_edges", cyc - d0, 4099);
        chk("to_offset", ifc.out_offset, 4'd1);
        data_step(k);
        data_step(k + 1);
        chk("to_blank", ifc.out_blank, 1'b1);
        chk("to_rgb", {ifc.out_red, ifc.out_green, ifc.out_blue}, 24'h0);

        mid_reset("rst1");
        wait_lock(64, took);
        chk("relock", ifc.out_locked, 1'b1);
        chk("relock_in_hblank", took <= 16, 1'b1);
        chk("relock_offset", ifc.out_offset, 4'd0);
        chk_en = 1'b1;
        repeat (64) stream_step();
        chk_en = 1'b0;
        while (lp != 30) stream_step();
        chk("pre_rst2_locked", ifc.out_locked, 1'b1);

        // rotated stream: symbol bit 0 sits at bit 7 of each word
        mid_reset("rst2");
        rot = 7;
        wait_lock(8 * 4096 + 500, took);
        chk("rot_locked", ifc.out_locked, 1'b1);
        chk("rot_slips", nslip, 7);
        chk("rot_offset", ifc.out_offset, 4'd7);
        chk_en = 1'b1;
        repeat (128) stream_step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
